bist_fail_log: RTL
==================

BIST_FAIL_LOG -- requirements
Module: bist_fail_log

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 6, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, 8, SRAM data width.
REQ-003 SHALL have parameter PATTERN_WIDTH, 3, width of the BIST pattern-select code.
REQ-004 SHALL have parameter DEPTH, 4, log entries; power of two, >=2.
REQ-005 SHALL have ports clk input 1 (single clock, all logic posedge), then rst input 1 (asynchronous, active-high reset).
REQ-006 SHALL have ports clr input 1 (synchronous log clear) and cmp_valid input 1 (BIST compare strobe: cmp_* valid this cycle).
REQ-007 SHALL have ports cmp_addr input ADDR_WIDTH, cmp_check input DATA_WIDTH (expected), cmp_dout input DATA_WIDTH (SRAM read data), cmp_pattern input PATTERN_WIDTH.
REQ-008 SHALL have ports rd_ready input 1, rd_valid output 1, rd_addr output ADDR_WIDTH, rd_pattern output PATTERN_WIDTH, rd_expected output DATA_WIDTH, rd_syndrome output DATA_WIDTH (expected XOR actual).
REQ-009 SHALL have ports count output $clog2(DEPTH)+1 (entries held), full output 1, fail_cnt output 16 (mismatches seen), overflow output 1 (sticky).

Function
REQ-010 Mismatch SHALL be defined as cmp_valid=1 and cmp_dout!=cmp_check; cmp_valid=0 SHALL never log or count.
REQ-011 Each mismatch SHALL increment fail_cnt by 1, saturating at 16'hFFFF, regardless of log occupancy.
REQ-012 A logged mismatch SHALL write {cmp_addr, cmp_pattern, cmp_check, cmp_check^cmp_dout} into a DEPTH-entry FIFO at the same posedge; visible at rd_* one cycle later (1-cycle latency).
REQ-013 rd_valid SHALL equal (count!=0); rd_* SHALL present the oldest entry and hold stable while rd_valid=1 and rd_ready=0.
REQ-014 Pop SHALL occur on posedge with rd_valid=1 and rd_ready=1; rd_* SHALL be don't-care when rd_valid=0.
REQ-015 Mismatch while full and no pop SHALL be dropped, set overflow=1, leave FIFO contents unchanged.
REQ-016 Simultaneous pop and logged mismatch SHALL both occur, count unchanged, including when full (no overflow).
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; full SHALL equal (count==DEPTH).
REQ-018 clr=1 SHALL at the next posedge empty the FIFO, zero fail_cnt, clear overflow; clr SHALL take priority over any simultaneous mismatch or pop.
REQ-019 Entry order SHALL be strictly first-in first-out; no entry SHALL be duplicated or reordered.

Reset
REQ-020 rst=1 SHALL asynchronously force count=0, rd_valid=0, full=0, fail_cnt=0, overflow=0, pointers=0.
REQ-021 Storage array contents SHALL NOT require reset.
REQ-022 rst asserted mid-operation SHALL discard all entries; first logged mismatch after rst deasserts SHALL appear at rd_* one cycle later.

Configuration
REQ-023 Macro BIST_FAIL_LOG_DEDUP_EN SHALL control consecutive-address deduplication.
REQ-024 With BIST_FAIL_LOG_DEDUP_EN defined, a mismatch whose cmp_addr equals the address of the most recently logged entry (since rst/clr) SHALL NOT be logged; fail_cnt SHALL still increment; the dropped mismatch SHALL NOT set overflow.
REQ-025 Without the macro, every mismatch SHALL be offered to the FIFO per REQ-012/REQ-015; no last-address register SHALL exist.

Verification
REQ-026 Reset then 64 compares with cmp_dout==cmp_check -> rd_valid=0, count=0, fail_cnt=0, overflow=0.
REQ-027 Single mismatch addr=6'h15, check=8'hA5, dout=8'hA4, pattern=3 -> next cycle rd_valid=1, rd_addr=6'h15, rd_expected=8'hA5, rd_syndrome=8'h01, rd_pattern=3, fail_cnt=1.
REQ-028 DEPTH=4, rd_ready=0, mismatches at addrs 1..6 -> count=4, full=1, overflow=1, fail_cnt=6; draining with rd_ready=1 yields addrs 1,2,3,4 in order.
REQ-029 Full log, cycle with rd_ready=1 and mismatch at addr 9 -> count stays 4, overflow stays 0, addr 9 popped last.
REQ-030 Two entries logged, then clr=1 with simultaneous mismatch -> next cycle count=0, fail_cnt=0, overflow=0; rst mid-stream -> same outputs asynchronously.
REQ-031 Dedup defined: mismatches at addrs 5,5,5,7 -> count=2 (entries 5,7), fail_cnt=4; undefined -> count=4.

Source files
------------

// File: rtl/bist_fail_log.sv
// ---------------------------------------------------------------------------
// bist_fail_log
//   Captures memory-BIST compare failures into a small FIFO. Every mismatch is
//   counted, and the log holds the address, pattern code, expected data and the
//   syndrome (expected XOR actual) so that failures can be read out in order.
//
// Ports
//   clk, rst        clock (posedge), asynchronous active-high reset
//   clr             synchronous clear of log, fail counter and overflow flag
//   cmp_valid       compare strobe; cmp_addr/cmp_check/cmp_dout/cmp_pattern valid
//   rd_ready        consumer accepts the entry shown on rd_*
//   rd_valid        log is not empty; rd_* shows the oldest entry
//   rd_addr/rd_pattern/rd_expected/rd_syndrome   oldest logged failure
//   count           number of entries held, full when count == DEPTH
//   fail_cnt        saturating count of all mismatches seen
//   overflow        sticky: a failure was dropped because the log was full
//
// Build option
//   BIST_FAIL_LOG_DEDUP_EN  when defined, a mismatch at the same address as the
//                           most recently logged entry is counted but not logged.
// ---------------------------------------------------------------------------
module bist_fail_log #(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 8,
  parameter int PATTERN_WIDTH = 3,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       cmp_valid,
  input  logic [ADDR_WIDTH-1:0]      cmp_addr,
  input  logic [DATA_WIDTH-1:0]      cmp_check,
  input  logic [DATA_WIDTH-1:0]      cmp_dout,
  input  logic [PATTERN_WIDTH-1:0]   cmp_pattern,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [PATTERN_WIDTH-1:0]   rd_pattern,
  output logic [DATA_WIDTH-1:0]      rd_expected,
  output logic [DATA_WIDTH-1:0]      rd_syndrome,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [15:0]                fail_cnt,
  output logic                       overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + PATTERN_WIDTH + 2 * DATA_WIDTH;

  // Log storage; no reset needed because occupancy is tracked by count_reg.
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [15:0]      fail_cnt_reg;
  logic             overflow_reg;

  logic mismatch;
  logic dup;
  logic offer;
  logic pop;
  logic push;
  logic drop;

`ifdef BIST_FAIL_LOG_DEDUP_EN
  logic [ADDR_WIDTH-1:0] last_addr_reg;
  logic                  last_valid_reg;
`endif

  always_comb begin
    mismatch = cmp_valid && (cmp_dout != cmp_check);
`ifdef BIST_FAIL_LOG_DEDUP_EN
    dup = last_valid_reg && (cmp_addr == last_addr_reg);
`else
    dup = 1'b0;
`endif
    offer = mismatch && !dup;
    pop   = rd_valid && rd_ready;
    // A pop in the same cycle frees a slot, so a full log still accepts.
    push  = offer && (!full || pop);
    drop  = offer && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      fail_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else if (clr) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      fail_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
      if (drop) overflow_reg <= 1'b1;
      if (mismatch && (fail_cnt_reg != 16'hFFFF)) fail_cnt_reg <= fail_cnt_reg + 16'd1;
    end
  end

`ifdef BIST_FAIL_LOG_DEDUP_EN
  // Address of the last entry actually written into the log.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr_reg  <= '0;
      last_valid_reg <= 1'b0;
    end else if (clr) begin
      last_addr_reg  <= '0;
      last_valid_reg <= 1'b0;
    end else if (push) begin
      last_addr_reg  <= cmp_addr;
      last_valid_reg <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr_reg] <= {cmp_addr, cmp_pattern, cmp_check, cmp_check ^ cmp_dout};
    end
  end

  assign {rd_addr, rd_pattern, rd_expected, rd_syndrome} = mem[rd_ptr_reg];
  assign rd_valid = (count_reg != '0);
  assign count    = count_reg;
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign fail_cnt = fail_cnt_reg;
  assign overflow = overflow_reg;

endmodule
